// File: rtl/mem_dma.sv
// mem_dma: initiator-side sequencer for the 512 x 12-bit Simplez memory.
// Dump mode reads a contiguous address range and streams each word out over
// a valid/ready port. Fill mode writes one constant word over a contiguous
// range. Address arithmetic wraps modulo 512.
module mem_dma (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        op,
  input  logic [8:0]  base,
  input  logic [8:0]  len,
  input  logic [11:0] fill_data,
  output logic [8:0]  mem_addr,
  output logic        mem_wr,
  output logic [11:0] mem_wdata,
  input  logic [11:0] mem_rdata,
  output logic [11:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done
);

  localparam int ADDR_W = 9;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_OUT  = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ADDR_W-1:0]   cnt;
  logic                hshake;
  logic                cnt_zero;

  // Next address; the 9-bit width gives the 511 -> 0 wrap for free.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // State register; reset forces IDLE at once, even between clock edges.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = op ? WR : RD_ADDR;
      RD_ADDR: state_nx = RD_OUT;
      RD_OUT:  if (hshake) state_nx = cnt_zero ? IDLE : RD_ADDR;
      WR:      if (cnt_zero) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Combinational status: busy flag, consumer handshake and last-word detect.
  always_comb begin
    busy     = (state != IDLE);
    hshake   = (state == RD_OUT) && dout_valid && dout_ready;
    cnt_zero = (cnt == '0);
  end

  // Registered memory-port and stream outputs; all clear on reset so a
  // pending write is abandoned and any word on dout is discarded.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_addr   <= '0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      cnt        <= '0;
    end else begin
      done <= (state != IDLE) && (state_nx == IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr <= base;
            cnt      <= len;
            if (op) begin
              mem_wr    <= 1'b1;
              mem_wdata <= fill_data;
            end
          end
        end
        RD_ADDR: begin
          // mem_addr has been stable for a full cycle, so the memory's
          // negedge update of mem_rdata belongs to this address.
          dout       <= mem_rdata;
          dout_valid <= 1'b1;
        end
        RD_OUT: begin
          if (hshake) begin
            dout_valid <= 1'b0;
            if (!cnt_zero) begin
              mem_addr <= addr_inc(mem_addr);
              cnt      <= cnt - {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        WR: begin
          if (cnt_zero) begin
            mem_wr <= 1'b0;
          end else begin
            mem_addr <= addr_inc(mem_addr);
            cnt      <= cnt - {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          mem_wr     <= 1'b0;
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

  // Keep the word width tied to the port declarations.
  if (DATA_W != 12) begin : g_width_guard
    $error("mem_dma word width must be 12");
  end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: a negedge-updated 512 x 12 memory model, directed
// commands with hand-computed expected words, write addresses and cycle
// numbers pushed into queues, and a monitor that pops and compares them.
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [8:0]  base = '0;
  logic [8:0]  len = '0;
  logic [11:0] fill_data = '0;
  logic [8:0]  mem_addr;
  logic        mem_wr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;
  logic [11:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        busy;
  logic        done;

  logic [11:0] mem [512];
  bit          loaded = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [11:0] data;
    logic [8:0]  addr;
    int          cyc;
  } exp_t;

  exp_t rdq[$];
  exp_t wrq[$];
  int   doneq[$];
  exp_t mr;
  exp_t mw;

  mem_dma dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .base(base), .len(len),
    .fill_data(fill_data), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: preload mem[i] = i, write and read at negedge.
  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) mem[i] = 12'(i);
      loaded = 1'b1;
    end
    if (mem_wr) mem[mem_addr] = mem_wdata;
    mem_rdata = mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic bad(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: observed 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake,
  // a write strobe or a done pulse.
  always @(negedge clk) begin
    if (rstn) begin
      if (dout_valid && dout_ready) begin
        if (rdq.size() == 0) bad("rd_unexpected", 32'(dout));
        else begin
          mr = rdq.pop_front();
          chk("rd_data", 32'(dout), 32'(mr.data));
          chk("rd_addr", 32'(mem_addr), 32'(mr.addr));
          chk("rd_cycle", 32'(cyc), 32'(mr.cyc));
        end
      end else if (dout_valid && rdq.size() != 0) begin
        chk("stall_dout", 32'(dout), 32'(rdq[0].data));
        chk("stall_addr", 32'(mem_addr), 32'(rdq[0].addr));
      end
      if (mem_wr) begin
        if (wrq.size() == 0) bad("wr_unexpected", 32'(mem_addr));
        else begin
          mw = wrq.pop_front();
          chk("wr_data", 32'(mem_wdata), 32'(mw.data));
          chk("wr_addr", 32'(mem_addr), 32'(mw.addr));
          chk("wr_cycle", 32'(cyc), 32'(mw.cyc));
        end
      end
      if (done) begin
        if (doneq.size() == 0) bad("done_unexpected", 32'(cyc));
        else begin
          chk("done_cycle", 32'(cyc), 32'(doneq.pop_front()));
          chk("done_busy", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [11:0] d, input logic [8:0] a, input int c);
    exp_t e;
    e.data = d; e.addr = a; e.cyc = c;
    rdq.push_back(e);
  endtask

  task automatic push_wr(input logic [11:0] d, input logic [8:0] a, input int c);
    exp_t e;
    e.data = d; e.addr = a; e.cyc = c;
    wrq.push_back(e);
  endtask

  // One-cycle start strobe; inputs are scrambled afterwards since the DUT
  // must only use the values captured with start.
  task automatic issue(input logic o, input logic [8:0] b, input logic [8:0] l,
                       input logic [11:0] d);
    op = o; base = b; len = l; fill_data = d; start = 1'b1;
    tick();
    start = 1'b0; op = ~o; base = ~b; len = ~l; fill_data = ~d;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((busy || rdq.size() != 0 || wrq.size() != 0 || doneq.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d reads, %0d writes, %0d dones still pending",
               rdq.size(), wrq.size(), doneq.size());
      rdq.delete(); wrq.delete(); doneq.delete();
    end
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int d;
    int n;
    int nbad;

    // Reset state, held and released
    repeat (3) tick();
    check_zero("rst");
    rstn = 1'b1;
    tick();
    check_zero("post_rst");

    // Dump mem[2..5], consumer always ready
    p = cyc + 1;
    push_rd(12'o0002, 9'd2, p + 1);
    push_rd(12'o0003, 9'd3, p + 3);
    push_rd(12'o0004, 9'd4, p + 5);
    push_rd(12'o0005, 9'd5, p + 7);
    doneq.push_back(p + 8);
    issue(1'b0, 9'd2, 9'd3, 12'o0000);
    wait_idle(50);

    // Same dump with 5 stall cycles while word o0003 is presented
    p = cyc + 1;
    push_rd(12'o0002, 9'd2, p + 1);
    push_rd(12'o0003, 9'd3, p + 8);
    push_rd(12'o0004, 9'd4, p + 10);
    push_rd(12'o0005, 9'd5, p + 12);
    doneq.push_back(p + 13);
    issue(1'b0, 9'd2, 9'd3, 12'o0000);
    repeat (3) tick();
    dout_ready = 1'b0;
    repeat (5) tick();
    dout_ready = 1'b1;
    wait_idle(50);

    // Fill across the wrap: 510, 511, 0, 1
    p = cyc + 1;
    for (int i = 0; i < 4; i++) push_wr(12'o7000, 9'(510 + i), p + i);
    doneq.push_back(p + 4);
    issue(1'b1, 9'd510, 9'd3, 12'o7000);
    wait_idle(50);

    // Dump back the filled words plus untouched mem[2]
    p = cyc + 1;
    for (int i = 0; i < 4; i++) push_rd(12'o7000, 9'(510 + i), p + 1 + 2 * i);
    push_rd(12'o0002, 9'd2, p + 9);
    doneq.push_back(p + 10);
    issue(1'b0, 9'd510, 9'd4, 12'o0000);
    wait_idle(50);

    // Single-word dump and single-word fill
    p = cyc + 1;
    push_rd(12'o0007, 9'd7, p + 1);
    doneq.push_back(p + 2);
    issue(1'b0, 9'd7, 9'd0, 12'o0000);
    wait_idle(50);
    p = cyc + 1;
    push_wr(12'o1234, 9'd100, p);
    doneq.push_back(p + 1);
    issue(1'b1, 9'd100, 9'd0, 12'o1234);
    wait_idle(50);
    chk("len0_neighbour", 32'(mem[101]), 32'd101);

    // Whole-memory fill from address 0
    p = cyc + 1;
    for (int i = 0; i < 512; i++) push_wr(12'o0055, 9'(i), p + i);
    doneq.push_back(p + 512);
    issue(1'b1, 9'd0, 9'd511, 12'o0055);
    wait_idle(600);
    nbad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== 12'o0055) nbad++;
    chk("fill512_mem", 32'(nbad), 32'd0);

    // Start while busy is ignored; start in the done cycle is accepted
    p = cyc + 1;
    d = p + 4;
    push_rd(12'o0055, 9'd10, p + 1);
    push_rd(12'o0055, 9'd11, p + 3);
    doneq.push_back(d);
    issue(1'b0, 9'd10, 9'd1, 12'o0000);
    tick();
    op = 1'b1; base = 9'd20; len = 9'd0; fill_data = 12'o7777; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (cyc < d && n < 20) begin
      tick();
      n++;
    end
    chk("done_cycle_reached", 32'(cyc), 32'(d));
    p = cyc + 1;
    push_wr(12'o0777, 9'd30, p);
    push_wr(12'o0777, 9'd31, p + 1);
    doneq.push_back(p + 2);
    issue(1'b1, 9'd30, 9'd1, 12'o0777);
    wait_idle(50);

    // Reset in the middle of a fill, between posedges
    p = cyc + 1;
    for (int i = 0; i < 4; i++) push_wr(12'o4444, 9'(200 + i), p + i);
    issue(1'b1, 9'd200, 9'd9, 12'o4444);
    repeat (4) tick();
    rstn = 1'b0;
    #1;
    chk("rst_async_wr", 32'(mem_wr), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    check_zero("midrst");
    chk("midrst_mem203", 32'(mem[203]), 32'(12'o4444));
    chk("midrst_mem204", 32'(mem[204]), 32'(12'o0055));
    chk("midrst_mem209", 32'(mem[209]), 32'(12'o0055));
    rstn = 1'b1;
    tick();
    check_zero("rel");
    p = cyc + 1;
    push_rd(12'o4444, 9'd200, p + 1);
    doneq.push_back(p + 2);
    issue(1'b0, 9'd200, 9'd0, 12'o0000);
    wait_idle(50);

    chk("rdq_empty", 32'(rdq.size()), 32'd0);
    chk("wrq_empty", 32'(wrq.size()), 32'd0);
    chk("doneq_empty", 32'(doneq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Sequencer that drives the 512 x 12-bit Simplez memory port from the initiator side. It operates in one of two modes. In dump mode it reads a contiguous address range and streams the words out over a valid/ready interface, for the octal/UART dump path. In fill mode it writes a constant word over a contiguous range, for clearing or patching memory before the CPU runs. It sits between the front-panel/debug logic and the memory's addr/wr/data_in/data_out port, in place of the CPU.

## Interface
Parameters: none (widths are fixed by the Simplez memory: 9-bit address, 12-bit word).

- clk  in  1  system clock; all state updates on posedge
- rstn  in  1  asynchronous, active-low reset
- start  in  1  command strobe; sampled only while idle
- op  in  1  0 = dump (read), 1 = fill (write)
- base  in  9  first address
- len  in  9  word count minus one (0 → 1 word, 511 → 512 words)
- fill_data  in  12  word written in fill mode
- mem_addr  out  9  memory address, registered
- mem_wr  out  1  memory write enable, registered
- mem_wdata  out  12  memory write data, registered
- mem_rdata  in  12  memory read data; the memory updates it on negedge clk
- dout  out  12  dumped word
- dout_valid  out  1  dout holds a word
- dout_ready  in  1  consumer accepts dout
- busy  out  1  command in progress (state != IDLE)
- done  out  1  one-cycle pulse at command completion

## Operation
- The reset value of every output is 0: mem_addr, mem_wr, mem_wdata, dout, dout_valid, busy, done.
- States: IDLE, RD_ADDR, RD_OUT, WR.
- IDLE, on start=1:
  - Latch mem_addr←base, cnt←len.
  - op=0 → RD_ADDR.
  - op=1 → WR, with mem_wr←1 and mem_wdata←fill_data.
  - fill_data, base, len and op are captured at start only; later changes are ignored.
- RD_ADDR, one cycle:
  - mem_addr is stable; the memory reads it at the mid-cycle negedge.
  - On the closing posedge: dout←mem_rdata, dout_valid←1 → RD_OUT.
- RD_OUT:
  - Hold dout, dout_valid and mem_addr until dout_valid && dout_ready.
  - On handshake with cnt=0: dout_valid←0, done←1 → IDLE.
  - On handshake with cnt≠0: dout_valid←0, mem_addr←mem_addr+1, cnt←cnt−1 → RD_ADDR.
- WR: mem_wr=1 for one cycle per word; the memory writes at the mid-cycle negedge.
  - cnt=0: mem_wr←0, done←1 → IDLE.
  - cnt≠0: mem_addr←mem_addr+1, cnt←cnt−1, stay in WR.
- mem_wr is never 1 outside the WR state.
- Address arithmetic is 9-bit modulo: 511+1 wraps to 0. A 512-word command covers the whole memory once.
- start while busy=1 is ignored; no queueing.
- done is 1 in exactly the first cycle back in IDLE; busy=0 in that same cycle. A start in that cycle is accepted.
- Reset mid-operation: state returns to IDLE and mem_wr drops to 0 asynchronously, so no further write occurs. Any word pending on dout is discarded (dout_valid=0).

## Timing
- Dump: the first dout_valid rises 2 cycles after the start cycle (IDLE→RD_ADDR→RD_OUT).
- Dump throughput with dout_ready held at 1 is one word per 2 cycles.
- Each extra cycle of dout_ready=0 adds one cycle; dout stays constant throughout.
- Fill: mem_wr rises on the posedge that samples start, and stays high for exactly len+1 consecutive cycles with mem_addr incrementing each cycle.
- done rises the posedge after the final write or handshake.
- Read data is valid at the posedge following the cycle in which mem_addr was presented. It is never captured in the cycle that mem_addr changes.

## Test plan
1. Dump with mem[2..5]=o0002..o0005, base=2, len=3, dout_ready=1 → dout sequence o0002, o0003, o0004, o0005, each with dout_valid high 1 cycle, words 2 cycles apart; done pulses once, on the cycle after the 4th handshake.
2. Same dump with dout_ready=0 for 5 cycles while word o0003 is presented → dout and mem_addr hold stable; the sequence still has no loss or duplication; total duration grows by exactly 5 cycles.
3. Fill with base=510, len=3, fill_data=o7000 → mem_wr high exactly 4 cycles at addresses 510, 511, 0, 1. A following dump confirms those four words equal o7000 and mem[2] is unchanged.
4. len=0 for each op → exactly one read handshake or one write cycle, then done. A 512-word fill from base=0 writes every address once.
5. start pulsed while busy (different base) → ignored and the current command completes unchanged. start asserted in the done cycle → the new command begins on the next cycle.
6. rstn asserted mid-fill, between posedges → mem_wr goes 0 immediately and addresses beyond the last completed write are unchanged. After rstn release all outputs are 0 and start is accepted.
